mem_wb_pipe_stage: RTL

//  Parametrised MEM/WB pipeline register with valid/ready handshake, flush and 2-entry skid buffer.

---
 rtl/mem_wb_pipe_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline register with a registered-ready handshake, flush and a 2-entry skid buffer.
// Optional performance counters (stall_cnt, bubble_cnt) are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 2
`ifdef MEM_WB_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_AW-1:0] in_wn,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_AW-1:0] out_wn,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef MEM_WB_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} stateT;

  stateT state, stateNext;
  logic  inReadyQ;

  logic [DATA_W-1:0] mainRd, mainAlu, skidRd, skidAlu;
  logic [REG_AW-1:0] mainWn, skidWn;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;

  logic accept, drain;
  logic loadMainIn, loadMainSkid, loadSkidIn, clrMain, clrSkid;

  always_comb begin
    accept       = in_valid & inReadyQ;
    drain        = (state != EMPTY) & out_ready;
    stateNext    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkidIn   = 1'b0;
    clrMain      = 1'b0;
    clrSkid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNext  = ONE;
          loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          loadMainIn = 1'b1;
        end else if (accept) begin
          stateNext  = FULL;
          loadSkidIn = 1'b1;
        end else if (drain) begin
          stateNext = EMPTY;
          clrMain   = 1'b1;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can move the state
        if (drain) begin
          stateNext    = ONE;
          loadMainSkid = 1'b1;
          clrSkid      = 1'b1;
        end
      end
      default: begin
        stateNext = EMPTY;
        clrMain   = 1'b1;
        clrSkid   = 1'b1;
      end
    endcase
    if (flush) begin
      stateNext    = EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkidIn   = 1'b0;
      clrMain      = 1'b1;
      clrSkid      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      inReadyQ <= 1'b1;
      mainRd   <= '0;
      mainAlu  <= '0;
      mainWn   <= '0;
      mainCtrl <= '0;
      skidRd   <= '0;
      skidAlu  <= '0;
      skidWn   <= '0;
      skidCtrl <= '0;
    end else begin
      state    <= stateNext;
      inReadyQ <= (stateNext != FULL);
      if (clrMain) begin
        mainRd   <= '0;
        mainAlu  <= '0;
        mainWn   <= '0;
        mainCtrl <= '0;
      end else if (loadMainIn) begin
        mainRd   <= in_rd;
        mainAlu  <= in_alu;
        mainWn   <= in_wn;
        mainCtrl <= in_ctrl;
      end else if (loadMainSkid) begin
        mainRd   <= skidRd;
        mainAlu  <= skidAlu;
        mainWn   <= skidWn;
        mainCtrl <= skidCtrl;
      end
      if (clrSkid) begin
        skidRd   <= '0;
        skidAlu  <= '0;
        skidWn   <= '0;
        skidCtrl <= '0;
      end else if (loadSkidIn) begin
        skidRd   <= in_rd;
        skidAlu  <= in_alu;
        skidWn   <= in_wn;
        skidCtrl <= in_ctrl;
      end
    end
  end

  // Main register is zeroed on every entry to EMPTY, so a bubble never carries regWrite
  assign in_ready  = inReadyQ;
  assign out_valid = (state != EMPTY);
  assign out_rd    = mainRd;
  assign out_alu   = mainAlu;
  assign out_wn    = mainWn;
  assign out_ctrl  = mainCtrl;

`ifdef MEM_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
